alu_serial_ctrl: RTL and testbench

//  Bit-serial sequencer for the 1-bit ALU slice (alu: out, cout, c, a, b, cin).

---
 rtl/alu_serial_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer around a 1-bit ALU slice.
// Latches two WIDTH-bit operands, an op code and a carry-in. It then feeds
// the slice one bit per clock, LSB first, and collects the result in a
// right-shifting register. The start/busy/done handshake lets a higher-level
// FSM share one slice.
// Optional feature: define ZERO_FLAG_EN to add a registered `zero` flag.
module alu_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy,
`ifdef ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_NOT  = 2'b11;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
`ifdef ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic slice_out, slice_cout;

  // 1-bit ALU slice: the op code selects the function; carry is produced only by ADD
  always_comb begin
    slice_out  = 1'b0;
    slice_cout = 1'b0;
    case (op_q)
      OP_PASS: slice_out = a_sh_q[0];
      OP_ADD: begin
        slice_out  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        slice_cout = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) |
                     (b_sh_q[0] & carry_q);
      end
      OP_AND:  slice_out = a_sh_q[0] & b_sh_q[0];
      OP_NOT:  slice_out = ~a_sh_q[0];
      default: slice_out = 1'b0;
    endcase
  end

  // Sequencer next-state: accept in IDLE/DONE, shift one bit per clock in RUN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d = {slice_out, result_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          // The final carry is visible only for ADD; other ops report 0
          cout_d  = (op_q == OP_ADD) ? slice_cout : 1'b0;
`ifdef ZERO_FLAG_EN
          zero_d  = (result_d == '0);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; async reset aborts any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      op_q     <= OP_PASS;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
`ifdef ZERO_FLAG_EN
  assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed-vector bench for alu_serial_ctrl (WIDTH=8).
module tb_alu_serial_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [7:0] a, b;
  logic       cin;
  logic [7:0] result;
  logic       cout, busy, done;
`ifdef ZERO_FLAG_EN
  logic       zero;
`endif

  int total = 0;
  int bad   = 0;

  alu_serial_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .result(result), .cout(cout), .busy(busy),
`ifdef ZERO_FLAG_EN
    .zero(zero),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Launch one op; lat = clocks from start edge to the first done (-1 on timeout)
  task automatic run_op(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb,
                        input logic c, output int lat);
    @(negedge clk);
    op = o; a = va; b = vb; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({result, cout, busy, done} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got result=%h cout=%b busy=%b done=%b want all 0",
               result, cout, busy, done);
    end
`ifdef ZERO_FLAG_EN
    total++;
    if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero: got %b want 0", zero); end
`endif
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_add;
    int lat;
    run_op(2'b01, 8'hFF, 8'h01, 1'b0, lat);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL add_latency: got %0d want 8", lat); end
    total++;
    if ({result, cout} !== {8'h00, 1'b1}) begin
      bad++; $display("FAIL add_ff_01: got %h/%b want 00/1", result, cout);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_at_done: got %b want 0", busy); end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", done); end
    total++;
    if (result !== 8'h00) begin bad++; $display("FAIL result_hold: got %h want 00", result); end
    run_op(2'b01, 8'h3C, 8'h42, 1'b1, lat);
    total++;
    if (lat !== 8 || {result, cout} !== {8'h7F, 1'b0}) begin
      bad++; $display("FAIL add_3c_42_c1: got lat=%0d %h/%b want 8 7f/0", lat, result, cout);
    end
  endtask

  task automatic test_logic_ops;
    int lat;
    run_op(2'b10, 8'hA5, 8'h0F, 1'b1, lat);
    total++;
    if (lat !== 8 || {result, cout} !== {8'h05, 1'b0}) begin
      bad++; $display("FAIL and_a5_0f: got lat=%0d %h/%b want 8 05/0", lat, result, cout);
    end
    run_op(2'b11, 8'h3C, 8'hFF, 1'b1, lat);
    total++;
    if (lat !== 8 || {result, cout} !== {8'hC3, 1'b0}) begin
      bad++; $display("FAIL not_3c: got lat=%0d %h/%b want 8 c3/0", lat, result, cout);
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    @(negedge clk);
    op = 2'b00; a = 8'h5A; b = 8'h00; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        total++;
        if (k !== 9 * ndone - 1 || result !== 8'h5A) begin
          bad++;
          $display("FAIL b2b_done_%0d: got cycle=%0d result=%h want cycle=%0d result=5a",
                   ndone, k, result, 9 * ndone - 1);
        end
      end
    end
    start = 1'b0;
    total++;
    if (ndone !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", ndone); end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_ignore_mid_run;
    int ndone = 0;
    int first = -1;
    @(negedge clk);
    op = 2'b00; a = 8'h5A; b = 8'h00; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin a = 8'h00; b = 8'hFF; op = 2'b01; cin = 1'b1; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first < 0) first = k;
      end
    end
    total++;
    if (ndone !== 1 || first !== 8) begin
      bad++; $display("FAIL mid_run_start: got dones=%0d first=%0d want 1 at 8", ndone, first);
    end
    total++;
    if ({result, cout} !== {8'h5A, 1'b0}) begin
      bad++; $display("FAIL operand_change: got %h/%b want 5a/0", result, cout);
    end
  endtask

  task automatic test_reset_mid_run;
    int ndone = 0;
    @(negedge clk);
    op = 2'b01; a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    total++;
    if ({result, cout, busy, done} !== 11'd0) begin
      bad++;
      $display("FAIL async_reset: got result=%h cout=%b busy=%b done=%b want all 0",
               result, cout, busy, done);
    end
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    total++;
    if (ndone !== 0) begin bad++; $display("FAIL reset_no_done: got %0d active cycles want 0", ndone); end
  endtask

  task automatic test_after_reset;
    int lat;
    run_op(2'b01, 8'h01, 8'h01, 1'b0, lat);
    total++;
    if (lat !== 8 || {result, cout} !== {8'h02, 1'b0}) begin
      bad++; $display("FAIL add_after_reset: got lat=%0d %h/%b want 8 02/0", lat, result, cout);
    end
  endtask

`ifdef ZERO_FLAG_EN
  task automatic test_zero_flag;
    int lat;
    run_op(2'b10, 8'hF0, 8'h0F, 1'b0, lat);
    total++;
    if (lat !== 8 || zero !== 1'b1 || result !== 8'h00) begin
      bad++; $display("FAIL zero_set: got lat=%0d zero=%b result=%h want 8 1 00", lat, zero, result);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (zero !== 1'b1) begin bad++; $display("FAIL zero_hold: got %b want 1", zero); end
    run_op(2'b01, 8'h01, 8'h00, 1'b0, lat);
    total++;
    if (zero !== 1'b0 || result !== 8'h01) begin
      bad++; $display("FAIL zero_clear: got zero=%b result=%h want 0 01", zero, result);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_logic_ops();
    test_back_to_back();
    test_ignore_mid_run();
    test_reset_mid_run();
    test_after_reset();
`ifdef ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
